hex_tx_formatter: RTL

//  Upstream feeder for the UART transmit pipe. Accepts one binary word per valid/ready handshake.

---
 rtl/hex_tx_formatter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/hex_tx_formatter.sv
// hex_tx_formatter
//   Feeds the UART transmit pipe with ASCII hex text. Each input word is
//   accepted on a valid/ready handshake and emitted one byte at a time as
//   "0x<digits>[\n]" through the pipe's push_back/data_out byte interface.
//   The formatter stalls whenever the pipe reports full, so the pipe FIFO is
//   never pushed while full. There is no internal FIFO; upstream is held off
//   through ready.
//
// Parameters
//   DATA_WIDTH     width of the input word, multiple of 4 (4..64)
//   PREFIX         1: emit "0x" before the digits, 0: no prefix
//   NEWLINE        1: emit 0x0A after the last digit, 0: no terminator
//   SUPPRESS_ZEROS 1: skip leading '0' digits (at least one digit is printed)
//
// Ports
//   clk        in   clock
//   rst        in   synchronous reset, active-high
//   valid      in   word available on data
//   data       in   word to print, sampled when valid && ready
//   ready      out  formatter idle, can accept a word
//   busy       out  word in progress (inverse of ready)
//   full       in   tx pipe FIFO full
//   push_back  out  one-cycle byte write strobe, registered
//   data_out   out  ASCII byte, registered, valid while push_back is high
//
// State table
//   S_IDLE  | waiting for a word, ready=1
//   S_PFX0  | next byte is '0' of the prefix
//   S_PFX1  | next byte is 'x' of the prefix
//   S_DIGIT | next byte is the hex digit at the top of the shift register
//   S_NL    | next byte is the newline terminator

module hex_tx_formatter #(
  parameter int DATA_WIDTH     = 64,
  parameter int PREFIX         = 1,
  parameter int NEWLINE        = 1,
  parameter int SUPPRESS_ZEROS = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ready,
  output logic                  busy,
  input  logic                  full,
  output logic                  push_back,
  output logic [7:0]            data_out
);

  localparam int N  = DATA_WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PFX0,
    S_PFX1,
    S_DIGIT,
    S_NL
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [IW-1:0]         r_idx;
  logic                  r_push;
  logic [7:0]            r_byte;

  logic                  w_accept;
  logic                  w_issue;
  logic                  w_can_issue;
  logic [7:0]            w_byte;
  logic [IW-1:0]         w_lead_zeros;
  logic [DATA_WIDTH-1:0] w_load_shift;
  logic [IW-1:0]         w_load_idx;

  // Number of leading zero nibbles, capped at N-1 so the least significant
  // digit is always printed (a zero word prints a single '0').
  function automatic logic [IW-1:0] f_lead_zeros(input logic [DATA_WIDTH-1:0] d);
    logic [IW-1:0] cnt;
    logic          stop;
    cnt  = '0;
    stop = 1'b0;
    for (int i = N - 1; i > 0; i--) begin
      if (!stop && (d[4*i +: 4] == 4'h0)) begin
        cnt = cnt + IW'(1);
      end else begin
        stop = 1'b1;
      end
    end
    return cnt;
  endfunction

  function automatic logic [7:0] f_hex_ascii(input logic [3:0] n);
    logic [7:0] r;
    if (n < 4'd10) begin
      r = 8'h30 + {4'h0, n};
    end else begin
      r = 8'h37 + {4'h0, n};
    end
    return r;
  endfunction

  // Leading-zero suppression is folded into the load: the word is pre-shifted
  // so the first printed digit sits at the top, and the digit index starts
  // lower. Entering S_DIGIT therefore costs no extra cycles.
  assign w_lead_zeros = (SUPPRESS_ZEROS != 0) ? f_lead_zeros(data) : '0;
  assign w_load_shift = data << {w_lead_zeros, 2'b00};
  assign w_load_idx   = LAST_IDX - w_lead_zeros;

  // A byte may only be issued when the pipe has room and no push went out in
  // this cycle; the latter forces full to be re-sampled after every push.
  assign w_can_issue = !full && !r_push;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    w_byte      = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (valid) begin
          w_accept    = 1'b1;
          w_state_nxt = (PREFIX != 0) ? S_PFX0 : S_DIGIT;
        end
      end
      S_PFX0: begin
        w_byte = 8'h30;
        if (w_can_issue) begin
          w_issue     = 1'b1;
          w_state_nxt = S_PFX1;
        end
      end
      S_PFX1: begin
        w_byte = 8'h78;
        if (w_can_issue) begin
          w_issue     = 1'b1;
          w_state_nxt = S_DIGIT;
        end
      end
      S_DIGIT: begin
        w_byte = f_hex_ascii(r_shift[DATA_WIDTH-1 -: 4]);
        if (w_can_issue) begin
          w_issue = 1'b1;
          if (r_idx == '0) begin
            w_state_nxt = (NEWLINE != 0) ? S_NL : S_IDLE;
          end
        end
      end
      S_NL: begin
        w_byte = 8'h0A;
        if (w_can_issue) begin
          w_issue     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_push  <= 1'b0;
      r_byte  <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_push  <= w_issue;
      if (w_issue) begin
        r_byte <= w_byte;
      end
      if (w_accept) begin
        r_shift <= w_load_shift;
        r_idx   <= w_load_idx;
      end else if (w_issue && (r_state == S_DIGIT)) begin
        r_shift <= r_shift << 4;
        if (r_idx != '0) begin
          r_idx <= r_idx - IW'(1);
        end
      end
    end
  end

  assign ready     = (r_state == S_IDLE);
  assign busy      = !ready;
  assign push_back = r_push;
  assign data_out  = r_byte;

endmodule
